// File: rtl/qspi_stream_arbiter.sv
// Two-requester arbiter for a shared QSPI continuous-read controller.
// Optional stats ports: define QSPI_ARB_STATS_EN.
module qspi_stream_arbiter #(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_start,
  input  logic [ADDR_BITS-2:0] req0_addr,
  input  logic                 req0_next,
  input  logic                 req0_stop,
  output logic                 req0_ready,
  input  logic                 req1_start,
  input  logic [ADDR_BITS-2:0] req1_addr,
  input  logic                 req1_next,
  input  logic                 req1_stop,
  output logic                 req1_ready,
  output logic [15:0]          rd_data,
  output logic                 spi_start_read,
  output logic                 spi_continue_read,
  output logic                 spi_stop_read,
  output logic [ADDR_BITS-1:0] spi_addr,
  input  logic                 spi_busy,
  input  logic [15:0]          spi_data
`ifdef QSPI_ARB_STATS_EN
  ,
  output logic [15:0]          preempt_count,
  output logic                 req1_starved
`endif
);

  localparam int PW = ADDR_BITS - 1;
  localparam logic [PW-1:0] P_ONE = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_G0,
    S_G1,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_active0;
  logic          r_active1;
  logic          r_grant;
  logic          r_started;
  logic [PW-1:0] r_ptr0;
  logic [PW-1:0] r_ptr1;
  logic          r_start;
  logic          r_cont;
  logic          r_stop;

  logic w_start;
  logic w_cont;
  logic w_stop;
  logic w_strobe;
  logic w_ready0;
  logic w_ready1;
  logic w_grant_nxt;
  logic w_inc0;
  logic w_inc1;
  logic w_preempt;

  assign w_strobe = r_start | r_cont | r_stop;
  assign w_ready0 = (r_state == S_G0) && r_started
                    && !spi_busy && !w_strobe;
  assign w_ready1 = (r_state == S_G1) && r_started
                    && !spi_busy && !w_strobe;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cont      = 1'b0;
    w_stop      = 1'b0;
    w_grant_nxt = r_grant;
    w_inc0      = 1'b0;
    w_inc1      = 1'b0;
    w_preempt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // hold off one cycle after a stop strobe
        if (!r_stop) begin
          if (r_active0 || req0_start) begin
            w_start     = 1'b1;
            w_grant_nxt = 1'b0;
            w_state_nxt = S_G0;
          end else if (r_active1 || req1_start) begin
            w_start     = 1'b1;
            w_grant_nxt = 1'b1;
            w_state_nxt = S_G1;
          end
        end
      end
      S_G0: begin
        if (req0_stop || req0_start || !r_active0) begin
          w_state_nxt = S_STOP;
        end else if (req0_next && w_ready0) begin
          w_cont = 1'b1;
          w_inc0 = 1'b1;
        end
      end
      S_G1: begin
        if (req1_stop || req1_start || !r_active1) begin
          w_state_nxt = S_STOP;
        end else if (r_active0 || req0_start) begin
          // a halfword consumed on the preempting cycle still counts
          w_state_nxt = S_STOP;
          w_preempt   = 1'b1;
          w_inc1      = req1_next && w_ready1;
        end else if (req1_next && w_ready1) begin
          w_cont = 1'b1;
          w_inc1 = 1'b1;
        end
      end
      S_STOP: begin
        if (!spi_busy) begin
          w_stop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active0 <= 1'b0;
      r_active1 <= 1'b0;
      r_ptr0    <= '0;
      r_ptr1    <= '0;
      r_grant   <= 1'b0;
      r_started <= 1'b0;
      r_start   <= 1'b0;
      r_cont    <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_start <= w_start;
      r_cont  <= w_cont;
      r_stop  <= w_stop;
      r_grant <= w_grant_nxt;
      if (w_start)     r_started <= 1'b1;
      else if (w_stop) r_started <= 1'b0;
      if (req0_start) begin
        r_active0 <= 1'b1;
        r_ptr0    <= req0_addr;
      end else begin
        if (req0_stop) r_active0 <= 1'b0;
        if (w_inc0)    r_ptr0    <= r_ptr0 + P_ONE;
      end
      if (req1_start) begin
        r_active1 <= 1'b1;
        r_ptr1    <= req1_addr;
      end else begin
        if (req1_stop) r_active1 <= 1'b0;
        if (w_inc1)    r_ptr1    <= r_ptr1 + P_ONE;
      end
    end
  end

  assign req0_ready        = w_ready0;
  assign req1_ready        = w_ready1;
  assign rd_data           = spi_data;
  assign spi_start_read    = r_start;
  assign spi_continue_read = r_cont;
  assign spi_stop_read     = r_stop;
  assign spi_addr          = {(r_grant ? r_ptr1 : r_ptr0), 1'b0};

`ifdef QSPI_ARB_STATS_EN
  logic [15:0] r_preempt_cnt;
  logic [15:0] r_starve_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_preempt_cnt <= '0;
      r_starve_cnt  <= '0;
    end else begin
      if (w_preempt && r_preempt_cnt != 16'hFFFF)
        r_preempt_cnt <= r_preempt_cnt + 16'd1;
      if (r_state == S_G1 || !r_active1)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != 16'hFFFF)
        r_starve_cnt <= r_starve_cnt + 16'd1;
    end
  end

  assign preempt_count = r_preempt_cnt;
  assign req1_starved  = (r_starve_cnt == 16'hFFFF);
`endif

endmodule

// File: tb/tb_qspi_stream_arbiter.sv
// Bench for qspi_stream_arbiter: directed scenarios plus random traffic
// against a stream-level model of both requesters and the controller.
module tb_qspi_stream_arbiter;

  localparam int AB = 24;
  localparam int PW = AB - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_start = 1'b0;
  logic [PW-1:0] req0_addr = '0;
  logic          req0_next = 1'b0;
  logic          req0_stop = 1'b0;
  logic          req0_ready;
  logic          req1_start = 1'b0;
  logic [PW-1:0] req1_addr = '0;
  logic          req1_next = 1'b0;
  logic          req1_stop = 1'b0;
  logic          req1_ready;
  logic [15:0]   rd_data;
  logic          spi_start_read;
  logic          spi_continue_read;
  logic          spi_stop_read;
  logic [AB-1:0] spi_addr;
  logic          spi_busy;
  logic [15:0]   spi_data;
`ifdef QSPI_ARB_STATS_EN
  logic [15:0]   preempt_count;
  logic          req1_starved;
`endif

  always #5 clk = ~clk;

  qspi_stream_arbiter #(.ADDR_BITS(AB)) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_start        (req0_start),
    .req0_addr         (req0_addr),
    .req0_next         (req0_next),
    .req0_stop         (req0_stop),
    .req0_ready        (req0_ready),
    .req1_start        (req1_start),
    .req1_addr         (req1_addr),
    .req1_next         (req1_next),
    .req1_stop         (req1_stop),
    .req1_ready        (req1_ready),
    .rd_data           (rd_data),
    .spi_start_read    (spi_start_read),
    .spi_continue_read (spi_continue_read),
    .spi_stop_read     (spi_stop_read),
    .spi_addr          (spi_addr),
    .spi_busy          (spi_busy),
    .spi_data          (spi_data)
`ifdef QSPI_ARB_STATS_EN
    ,
    .preempt_count     (preempt_count),
    .req1_starved      (req1_starved)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [PW-1:0] a);
    return a[15:0] ^ 16'h3C5A ^ {9'd0, a[22:16]};
  endfunction

  // flash controller: busy for a few cycles after start/continue
  logic [1:0]    bcnt;
  logic [PW-1:0] cur;
  bit            fixed_lat = 1'b1;

  assign spi_busy = (bcnt != 2'd0);
  assign spi_data = mem(cur);

  always @(posedge clk) begin
    if (rst) begin
      bcnt <= 2'd0;
      cur  <= '0;
    end else if (spi_start_read || spi_continue_read) begin
      bcnt <= fixed_lat ? 2'd2 : 2'($urandom_range(1, 3));
      cur  <= spi_addr[AB-1:1];
    end else if (bcnt != 2'd0) begin
      bcnt <= bcnt - 2'd1;
    end
  end

  // requester-level model: next unconsumed halfword per stream
  logic          ma0, ma1, msel0, mg;
  logic [PW-1:0] mp0, mp1;
  int            wait0, wait1;

  always @(posedge clk) begin
    if (rst) begin
      ma0 <= 0; ma1 <= 0; msel0 <= 0; mg <= 0;
      mp0 <= '0; mp1 <= '0;
      wait0 <= 0; wait1 <= 0;
    end else begin
      msel0 <= ma0 || req0_start;
      if (spi_start_read) mg <= !msel0;
      if (req0_start) begin
        mp0 <= req0_addr; ma0 <= 1;
      end else if (req0_stop) ma0 <= 0;
      else if (req0_next && req0_ready) mp0 <= mp0 + 1'b1;
      if (req1_start) begin
        mp1 <= req1_addr; ma1 <= 1;
      end else if (req1_stop) ma1 <= 0;
      else if (req1_next && req1_ready) mp1 <= mp1 + 1'b1;
      wait0 <= (ma0 && !req0_ready && !req0_start) ? wait0 + 1 : 0;
      wait1 <= (ma1 && !ma0 && !req1_ready && !req1_start && !req0_stop)
               ? wait1 + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot", 32'($countones({spi_start_read, spi_continue_read,
                                   spi_stop_read}) <= 1), 1);
      chk("excl", 32'(req0_ready && req1_ready), 0);
      if (req0_ready) chk("rd0", rd_data, mem(mp0));
      if (req1_ready) chk("rd1", rd_data, mem(mp1));
      if (spi_start_read)
        chk("start_addr", spi_addr, {(msel0 ? mp0 : mp1), 1'b0});
      if (spi_continue_read)
        chk("cont_addr", spi_addr, {(mg ? mp1 : mp0), 1'b0});
      chk("live0", 32'(wait0 > 30), 0);
      chk("live1", 32'(wait1 > 30), 0);
    end
  end

  task automatic wait_for(input int which, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (which == 0)      seen = req0_ready;
      else if (which == 1) seen = req1_ready;
      else if (which == 2) seen = spi_start_read;
      else                 seen = spi_stop_read;
    end
    chk(tag, 32'(seen), 1);
  endtask

  function automatic logic [2:0] strobes();
    return {spi_start_read, spi_continue_read, spi_stop_read};
  endfunction

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'(strobes()), 0);
    chk("rst_rdy0", 32'(req0_ready), 0);
    chk("rst_rdy1", 32'(req1_ready), 0);
    rst = 1'b0;

    @(negedge clk);
    req0_addr = 23'h100; req0_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0;
    chk("t1_start", 32'(spi_start_read), 1);
    chk("t1_addr", spi_addr, 24'h200);
    wait_for(0, "t1_rdy0");
    chk("t1_data", rd_data, mem(23'h100));

    for (int k = 1; k <= 3; k++) begin
      if (!req0_ready) wait_for(0, "t2_rdy");
      req0_next = 1'b1;
      @(negedge clk);
      req0_next = 1'b0;
      chk("t2_cont", 32'(spi_continue_read), 1);
      chk("t2_addr", spi_addr, 32'((32'h100 + k) * 2));
    end
    @(negedge clk);
    chk("t2_busy", 32'(spi_busy), 1);
    req0_next = 1'b1;
    @(negedge clk);
    req0_next = 1'b0;
    chk("t2_nostrobe", 32'(strobes()), 0);
    chk("t2_ptr", spi_addr, 24'h206);
    wait_for(0, "t2_rdy0");
    chk("t2_data", rd_data, mem(23'h103));

    req0_stop = 1'b1;
    @(negedge clk);
    req0_stop = 1'b0;
    wait_for(3, "t3_stop0");
    @(negedge clk);
    req1_addr = 23'h40; req1_start = 1'b1;
    @(negedge clk);
    req1_start = 1'b0;
    chk("t3_start1", 32'(spi_start_read), 1);
    chk("t3_addr1", spi_addr, 24'h80);
    for (int k = 0; k < 2; k++) begin
      if (!req1_ready) wait_for(1, "t3_rdy1");
      req1_next = 1'b1;
      @(negedge clk);
      req1_next = 1'b0;
    end
    req0_addr = 23'h800; req0_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0;
    wait_for(3, "t3_pstop");
    wait_for(2, "t3_pstart");
    chk("t3_paddr", spi_addr, 24'h1000);
`ifdef QSPI_ARB_STATS_EN
    chk("t3_pcnt", preempt_count, 1);
`endif
    wait_for(0, "t3_rdy0");
    req0_stop = 1'b1;
    @(negedge clk);
    req0_stop = 1'b0;
    wait_for(3, "t3_stop");
    wait_for(2, "t3_resume");
    chk("t3_raddr", spi_addr, 24'h84);
    wait_for(1, "t3_rrdy");
    chk("t3_rdata", rd_data, mem(23'h42));

    req1_stop = 1'b1;
    @(negedge clk);
    req1_stop = 1'b0;
    wait_for(3, "t4_stop1");
    @(negedge clk);
    req0_addr = 23'h10; req1_addr = 23'h20;
    req0_start = 1'b1; req1_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0; req1_start = 1'b0;
    chk("t4_start", 32'(spi_start_read), 1);
    chk("t4_addr0", spi_addr, 24'h20);
    wait_for(0, "t4_rdy0");
    req0_stop = 1'b1;
    @(negedge clk);
    req0_stop = 1'b0;
    wait_for(3, "t4_stop0");
    wait_for(2, "t4_start1");
    chk("t4_addr1", spi_addr, 24'h40);

    wait_for(1, "t5_rdy1");
    req0_addr = 23'h300; req0_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0;
    wait_for(3, "t5_pstop");
    wait_for(2, "t5_pstart");
    chk("t5_paddr", spi_addr, 24'h600);
    wait_for(0, "t5_rdy0");
    req1_stop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req1_stop = 1'b0;
      chk("t5_quiet", 32'(strobes()), 0);
    end
`ifdef QSPI_ARB_STATS_EN
    chk("t5_pcnt", preempt_count, 2);
`endif
    req0_stop = 1'b1;
    @(negedge clk);
    req0_stop = 1'b0;
    wait_for(3, "t5_stop0");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_idle", 32'(spi_start_read), 0);
    end

    fixed_lat = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req0_start = ($urandom_range(0, 39) == 0);
      req0_stop  = !req0_start && ($urandom_range(0, 29) == 0);
      req0_next  = ($urandom_range(0, 2) == 0);
      req0_addr  = ($urandom_range(0, 3) == 0) ? 23'h7FFFFE
                                                : 23'($urandom);
      req1_start = ($urandom_range(0, 24) == 0);
      req1_stop  = !req1_start && ($urandom_range(0, 39) == 0);
      req1_next  = ($urandom_range(0, 1) == 0);
      req1_addr  = 23'($urandom);
    end
    @(negedge clk);
    req0_start = 0; req0_stop = 0; req0_next = 0;
    req1_start = 0; req1_stop = 0; req1_next = 0;

    repeat (40) @(negedge clk);
    req0_addr = 23'h77; req0_start = 1'b1;
    @(negedge clk);
    req0_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_strobes", 32'(strobes()), 0);
    chk("rst2_rdy0", 32'(req0_ready), 0);
    chk("rst2_rdy1", 32'(req1_ready), 0);
`ifdef QSPI_ARB_STATS_EN
    chk("rst2_pcnt", preempt_count, 0);
    chk("rst2_starve", 32'(req1_starved), 0);
`endif
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst2_nostart", 32'(strobes()), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
